// File: rtl/stall_ctrl.sv
// Pipeline hazard and stall controller: resolves load-use hazards, taken branches,
// data-memory waits and debug halts into PC / pipeline-register enables and flushes.
module stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_is_load,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic        mem_busy,
  input  logic        halt_req,
  output logic        pc_enable,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_target,
  output logic        if_id_enable,
  output logic        id_ex_enable,
  output logic        ex_mem_enable,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halted,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_pend_valid;
  logic        w_pend_valid_nxt;
  logic [31:0] r_pend_target;
  logic [31:0] w_pend_target_nxt;
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic        w_rs1_hit;
  logic        w_rs2_hit;
  logic        w_lu;
  logic        w_run_eval;

  assign w_rs1_hit = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign w_rs2_hit = id_rs2_used && (id_rs2_addr == ex_rd_addr);
  assign w_lu      = ex_is_load && (ex_rd_addr != 5'd0) && (w_rs1_hit || w_rs2_hit);

  // Cycles that apply the normal RUN priority: RUN itself, a memory wait ending
  // with no redirect pending, and a halt being released.
  assign w_run_eval = (r_state == ST_RUN) ||
                      ((r_state == ST_MEM_WAIT) && !mem_busy && !r_pend_valid) ||
                      ((r_state == ST_HALT) && !halt_req);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'd0;
    end else begin
      r_state       <= w_next_state;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state      = r_state;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_target_nxt = r_pend_target;

    if (w_run_eval) begin
      if (mem_busy) begin
        w_next_state = ST_MEM_WAIT;
        if (ex_br_taken) begin
          w_pend_valid_nxt  = 1'b1;
          w_pend_target_nxt = ex_br_target;
        end
      end else if (ex_br_taken) begin
        w_next_state = ST_RUN;
      end else if (halt_req) begin
        w_next_state = ST_HALT;
      end else begin
        w_next_state = ST_RUN;
      end
    end else begin
      case (r_state)
        // Reaching here with mem_busy low means a redirect is pending.
        ST_MEM_WAIT: if (!mem_busy) w_next_state = ST_DRAIN;
        ST_DRAIN: begin
          if (mem_busy) begin
            w_next_state = ST_MEM_WAIT;
          end else begin
            w_next_state     = ST_RUN;
            w_pend_valid_nxt = 1'b0;
          end
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_enable          = 1'b1;
    pc_redirect        = 1'b0;
    pc_redirect_target = 32'd0;
    if_id_enable       = 1'b1;
    id_ex_enable       = 1'b1;
    ex_mem_enable      = 1'b1;
    if_id_flush        = 1'b0;
    id_ex_flush        = 1'b0;
    halted             = 1'b0;

    if (rst) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (w_run_eval) begin
      pc_redirect_target = ex_br_target;
      if (mem_busy) begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
      end else if (ex_br_taken) begin
        pc_redirect = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (halt_req || w_lu) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_flush  = 1'b1;
      end
    end else begin
      case (r_state)
        ST_MEM_WAIT: begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          id_ex_enable  = 1'b0;
          ex_mem_enable = 1'b0;
        end
        ST_DRAIN: begin
          pc_redirect_target = r_pend_target;
          if (mem_busy) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
          end else begin
            pc_redirect = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        ST_HALT: begin
          halted       = 1'b1;
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
          if (mem_busy) begin
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
          end
        end
        default: halted = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (!pc_enable && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (pc_redirect && (r_flush_cnt != 16'hFFFF))     r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  asynchronous, active-high reset.
REQ-003: id_rs1_addr, id_rs2_addr  input  5 each  source registers of the instruction in ID.
REQ-004: id_rs1_used, id_rs2_used  input  1 each  ID instruction reads rs1 / rs2.
REQ-005: ex_rd_addr  input  5  destination register of the instruction in EX.
REQ-006: ex_is_load  input  1  instruction in EX is a load.
REQ-007: ex_br_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-008: ex_br_target  input  32  redirect target, valid when ex_br_taken=1.
REQ-009: mem_busy  input  1  data-memory access not complete; pipeline must freeze.
REQ-010: halt_req  input  1  level-sensitive debug halt request.
REQ-011: pc_enable  output  1  PC register load enable.
REQ-012: pc_redirect  output  1  select pc_redirect_target as next PC.
REQ-013: pc_redirect_target  output  32  redirect address.
REQ-014: if_id_enable, id_ex_enable, ex_mem_enable  output  1 each  pipeline register enables.
REQ-015: if_id_flush, id_ex_flush  output  1 each  insert bubble into IF/ID, ID/EX.
REQ-016: halted  output  1  core is in HALT state.
REQ-017: stall_cnt  output  32  saturating count of cycles with pc_enable=0.
REQ-018: flush_cnt  output  16  saturating count of applied redirects.

Function
REQ-019: States RUN, MEM_WAIT, DRAIN, HALT; state, pend_valid, pend_target and counters are registered; all other outputs are combinational from state and current inputs.
REQ-020: Load-use hazard (lu) = ex_is_load & ex_rd_addr!=0 & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
REQ-021: Default outputs: pc_enable=1, all enables=1, flushes=0, pc_redirect=0.
REQ-022: RUN priority: mem_busy > ex_br_taken > halt_req > lu.
REQ-023: RUN & mem_busy: pc_enable=0, all enables=0, no flushes; if ex_br_taken same cycle, capture pend_valid=1, pend_target=ex_br_target; next state MEM_WAIT.
REQ-024: RUN & ex_br_taken & !mem_busy: pc_redirect=1, target=ex_br_target, pc_enable=1, if_id_flush=1, id_ex_flush=1; lu ignored; stays RUN.
REQ-025: RUN & halt_req (no mem_busy, no branch): pc_enable=0, if_id_enable=0, id_ex_flush=1; next state HALT.
REQ-026: RUN & lu only: pc_enable=0, if_id_enable=0, id_ex_flush=1 for exactly that cycle; stays RUN.
REQ-027: MEM_WAIT: freeze as REQ-023 while mem_busy=1; ex_br_taken ignored (EX frozen). On mem_busy=0: if pend_valid then DRAIN with outputs still frozen that cycle, else RUN with REQ-022 evaluation that cycle.
REQ-028: DRAIN (one cycle): pc_redirect=1, target=pend_target, pc_enable=1, if_id_flush=1, id_ex_flush=1; clear pend_valid; next RUN; mem_busy=1 in DRAIN freezes and returns to MEM_WAIT keeping pend_valid.
REQ-029: HALT: pc_enable=0, if_id_enable=0, id_ex_flush=1, halted=1; exit to RUN when halt_req=0; mem_busy=1 in HALT also freezes id_ex/ex_mem enables.
REQ-030: pc_redirect_target=ex_br_target in RUN, pend_target in DRAIN, 0 otherwise.
REQ-031: stall_cnt increments each cycle pc_enable=0, saturates at 0xFFFFFFFF; flush_cnt increments each cycle pc_redirect=1, saturates at 0xFFFF.

Reset
REQ-032: While rst=1: state=RUN, pend_valid=0, pend_target=0, counters=0, pc_enable=0, all enables=0, if_id_flush=1, id_ex_flush=1, pc_redirect=0, halted=0.
REQ-033: rst mid-MEM_WAIT/DRAIN discards pending redirect; first cycle after release evaluates REQ-022.

Verification
REQ-034: ex_is_load=1, ex_rd=5, id_rs1_used=1, id_rs1=5 for 1 cycle -> pc_enable=0, id_ex_flush=1 that cycle only, stall_cnt=1.
REQ-035: Same as REQ-034 but ex_rd=0 -> no stall, stall_cnt=0.
REQ-036: ex_br_taken=1, target 0x0000_0100, lu=1 same cycle -> pc_redirect=1, target 0x100, both flushes=1, flush_cnt=1, stall_cnt unchanged.
REQ-037: mem_busy=1 3 cycles with ex_br_taken=1 (target 0x200) in first cycle -> 3 frozen cycles, 1 frozen cycle on mem_busy fall, then DRAIN redirect to 0x200; stall_cnt=4, flush_cnt=1.
REQ-038: halt_req=1 for 5 cycles -> halted=1 from next cycle, pc_enable=0 for 5 cycles, RUN and pc_enable=1 the cycle halt_req=0.
REQ-039: rst asserted during MEM_WAIT with pend_valid=1 -> after release no redirect, counters 0.
